// File: rtl/instruction_fetch_stage.sv
// Fetch stage of the pipelined MIPS core: PC register and IF/ID pipeline register.
// It drives the combinational instruction ROM, handles redirect, stall and flush, and flags bad fetch addresses.
module instruction_fetch_stage #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter int          CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  redirect_en,
    input  logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic [DATA_WIDTH-1:0] rom_q,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    output logic [DATA_WIDTH-1:0] pc_if,
    output logic [DATA_WIDTH-1:0] instr_id,
    output logic [DATA_WIDTH-1:0] pc_plus4_id,
    output logic                  valid_id,
    output logic                  addr_err,
    output logic [CNT_WIDTH-1:0]  fetch_count
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_instr;
    logic [DATA_WIDTH-1:0] r_pc_plus4;
    logic                  r_valid;
    logic                  r_err;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic [DATA_WIDTH-1:0] w_off;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic                  w_in_range;

    // Offset into the text segment; anything at or beyond 2**ADDR_WIDTH words misses the ROM.
    assign w_off      = r_pc - DATA_WIDTH'(RESET_PC);
    assign w_pc_plus4 = r_pc + DATA_WIDTH'(4);
    assign w_in_range = ((w_off >> (ADDR_WIDTH + 2)) == '0);
    assign rom_addr   = w_off[ADDR_WIDTH+1:2];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc       <= DATA_WIDTH'(RESET_PC);
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_cnt      <= '0;
        end else if (redirect_en) begin
            r_pc       <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
            if (redirect_pc[1:0] != 2'b00) r_err <= 1'b1;
        end else if (stall) begin
            if (flush) begin
                r_instr    <= '0;
                r_pc_plus4 <= '0;
                r_valid    <= 1'b0;
            end
        end else if (flush) begin
            r_pc       <= w_pc_plus4;
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_pc <= w_pc_plus4;
            if (w_in_range) begin
                r_instr    <= rom_q;
                r_pc_plus4 <= w_pc_plus4;
                r_valid    <= 1'b1;
                if (r_cnt != '1) r_cnt <= r_cnt + CNT_WIDTH'(1);
            end else begin
                r_instr    <= '0;
                r_pc_plus4 <= '0;
                r_valid    <= 1'b0;
                r_err      <= 1'b1;
            end
        end
    end

    assign pc_if       = r_pc;
    assign instr_id    = r_instr;
    assign pc_plus4_id = r_pc_plus4;
    assign valid_id    = r_valid;
    assign addr_err    = r_err;
    assign fetch_count = r_cnt;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Bench for instruction_fetch_stage: a directed vector table, then random traffic checked against a reference model.
module tb_instruction_fetch_stage;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset, stall, flush, redirect_en;
    logic [31:0] redirect_pc;
    logic [31:0] rom_q;
    logic [7:0]  rom_addr, rom_addr_s;
    logic [31:0] pc_if, instr_id, pc_plus4_id;
    logic [31:0] pc_if_s, instr_id_s, pc_plus4_id_s;
    logic        valid_id, addr_err, valid_id_s, addr_err_s;
    logic [15:0] fetch_count;
    logic [2:0]  fetch_count_s;

    logic [31:0] rom [256];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign rom_q = rom[rom_addr];

    instruction_fetch_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .rom_q(rom_q),
        .rom_addr(rom_addr), .pc_if(pc_if), .instr_id(instr_id),
        .pc_plus4_id(pc_plus4_id), .valid_id(valid_id), .addr_err(addr_err),
        .fetch_count(fetch_count)
    );

    // Narrow counter copy so that saturation is reachable in a short run.
    instruction_fetch_stage #(.CNT_WIDTH(3)) dut_sat (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .rom_q(rom_q),
        .rom_addr(rom_addr_s), .pc_if(pc_if_s), .instr_id(instr_id_s),
        .pc_plus4_id(pc_plus4_id_s), .valid_id(valid_id_s), .addr_err(addr_err_s),
        .fetch_count(fetch_count_s)
    );

    typedef struct {
        logic        rst, stl, fl, re;
        logic [31:0] rpc;
        logic [31:0] pc, instr, p4;
        logic [7:0]  ra;
        logic        v, err;
        int          cnt;
    } vec_t;

    vec_t vt [$];

    // Reference model state
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_v, m_err;
    int          m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, stl, fl, re, input logic [31:0] rpc,
                                input logic [31:0] pc, instr, p4, input logic v, err, input int cnt);
        vec_t r;
        r.rst = rst; r.stl = stl; r.fl = fl; r.re = re; r.rpc = rpc;
        r.pc = pc; r.instr = instr; r.p4 = p4; r.v = v; r.err = err; r.cnt = cnt;
        r.ra = 8'((pc - BASE) >> 2);
        return r;
    endfunction

    function automatic int sat(input int c, input int mx);
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_step(input logic r, s, f, re, input logic [31:0] rpc);
        logic [31:0] off;
        if (r) begin
            m_pc = BASE; m_instr = 0; m_p4 = 0; m_v = 0; m_err = 0; m_cnt = 0;
        end else if (re) begin
            m_pc = {rpc[31:2], 2'b00}; m_instr = 0; m_p4 = 0; m_v = 0;
            if (rpc[1:0] != 2'b00) m_err = 1;
        end else if (s) begin
            if (f) begin m_instr = 0; m_p4 = 0; m_v = 0; end
        end else if (f) begin
            m_pc = m_pc + 4; m_instr = 0; m_p4 = 0; m_v = 0;
        end else begin
            off = m_pc - BASE;
            if (off / 4 < 256) begin
                m_instr = rom[off / 4]; m_p4 = m_pc + 4; m_v = 1; m_cnt++;
            end else begin
                m_instr = 0; m_p4 = 0; m_v = 0; m_err = 1;
            end
            m_pc = m_pc + 4;
        end
    endtask

    task automatic drive_edge(input logic r, s, f, re, input logic [31:0] rpc);
        reset = r; stall = s; flush = f; redirect_en = re; redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("pc_if", pc_if, m_pc);
        chk("rom_addr", {24'h0, rom_addr}, {24'h0, 8'((m_pc - BASE) >> 2)});
        chk("instr_id", instr_id, m_instr);
        chk("pc_plus4_id", pc_plus4_id, m_p4);
        chk("valid_id", {31'h0, valid_id}, {31'h0, m_v});
        chk("addr_err", {31'h0, addr_err}, {31'h0, m_err});
        chk("fetch_count", {16'h0, fetch_count}, 32'(sat(m_cnt, 65535)));
        chk("fetch_count_sat", {29'h0, fetch_count_s}, 32'(sat(m_cnt, 7)));
    endtask

    initial begin
        rom[0] = 32'h2008_0005; rom[1] = 32'h2009_0003;
        rom[2] = 32'h0109_5020; rom[3] = 32'hAC0A_0000;
        for (int i = 4; i < 256; i++) rom[i] = 32'h1000_0000 + i;

        reset = 1; stall = 0; flush = 0; redirect_en = 0; redirect_pc = 0;

        //          rst stl fl re rpc           pc            instr          p4            v  err cnt
        vt.push_back(mk(1, 0, 0, 0, 0,            BASE,         0,             0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 0,            32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 0, 2));
        for (int k = 0; k < 3; k++)
            vt.push_back(mk(0, 1, 0, 0, 0,        32'h0040_0008, 32'h2009_0003, 32'h0040_0008, 1, 0, 2));
        vt.push_back(mk(0, 0, 0, 0, 0,            32'h0040_000C, 32'h0109_5020, 32'h0040_000C, 1, 0, 3));
        vt.push_back(mk(0, 0, 0, 0, 0,            32'h0040_0010, 32'hAC0A_0000, 32'h0040_0010, 1, 0, 4));
        vt.push_back(mk(0, 1, 0, 1, 32'h0040_0020, 32'h0040_0020, 0,            0,            0, 0, 4));
        vt.push_back(mk(0, 0, 0, 0, 0,            32'h0040_0024, 32'h1000_0008, 32'h0040_0024, 1, 0, 5));
        vt.push_back(mk(1, 0, 0, 0, 0,            BASE,         0,             0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            32'h0040_0004, 32'h2008_0005, 32'h0040_0004, 1, 0, 1));
        vt.push_back(mk(0, 0, 1, 0, 0,            32'h0040_0008, 0,             0,            0, 0, 1));
        vt.push_back(mk(0, 0, 0, 1, 32'h0040_0006, 32'h0040_0004, 0,            0,            0, 1, 1));
        for (int k = 0; k < 10; k++)
            vt.push_back(mk(0, 0, 0, 0, 0, 32'h0040_0008 + 4 * k, rom[1 + k],
                            32'h0040_0008 + 4 * k, 1, 1, 2 + k));
        vt.push_back(mk(1, 0, 0, 0, 0,            BASE,         0,             0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 1, 32'h0040_0400, 32'h0040_0400, 0,            0,            0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0,            32'h0040_0404, 0,             0,            0, 1, 0));

        for (int i = 0; i < vt.size(); i++) begin
            drive_edge(vt[i].rst, vt[i].stl, vt[i].fl, vt[i].re, vt[i].rpc);
            chk($sformatf("v%0d.pc_if", i), pc_if, vt[i].pc);
            chk($sformatf("v%0d.rom_addr", i), {24'h0, rom_addr}, {24'h0, vt[i].ra});
            chk($sformatf("v%0d.instr_id", i), instr_id, vt[i].instr);
            chk($sformatf("v%0d.pc_plus4_id", i), pc_plus4_id, vt[i].p4);
            chk($sformatf("v%0d.valid_id", i), {31'h0, valid_id}, {31'h0, vt[i].v});
            chk($sformatf("v%0d.addr_err", i), {31'h0, addr_err}, {31'h0, vt[i].err});
            chk($sformatf("v%0d.fetch_count", i), {16'h0, fetch_count}, 32'(vt[i].cnt));
            chk($sformatf("v%0d.fetch_count_sat", i), {29'h0, fetch_count_s}, 32'(sat(vt[i].cnt, 7)));
        end

        // Random traffic from a fresh reset, mirrored by the reference model.
        drive_edge(1, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0);
        check_model();
        for (int n = 0; n < 3000; n++) begin
            logic        r, s, f, re;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 99) == 0);
            s   = ($urandom_range(0, 4) == 0);
            f   = ($urandom_range(0, 5) == 0);
            re  = ($urandom_range(0, 9) == 0);
            rpc = BASE + ($urandom_range(0, 280) << 2);
            if ($urandom_range(0, 7) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 31) == 0) rpc = $urandom;
            drive_edge(r, s, f, re, rpc);
            model_step(r, s, f, re, rpc);
            check_model();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_stage.md
Name: instruction_fetch_stage

Overview:
- PC register plus IF/ID pipeline register for the pipelined MIPS core.
- Drives the word address of the combinational instruction ROM and samples the returned instruction into the IF/ID register.
- Handles stall, flush and PC redirect requests for branch, jump, jal and jr from later stages.
- Flags misaligned or out-of-range fetch addresses.

Parameters:
- DATA_WIDTH, 32, instruction and PC width.
- ADDR_WIDTH, 8, ROM word-address width; ROM holds 2**ADDR_WIDTH words.
- RESET_PC, 32'h0040_0000, PC value after reset; base of the text segment.
- CNT_WIDTH, 16, width of the fetch counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard unit: hold PC and IF/ID.
- flush  in  1  insert a bubble into IF/ID.
- redirect_en  in  1  load PC from redirect_pc (taken branch, j, jal, jr).
- redirect_pc  in  DATA_WIDTH  redirect target byte address.
- rom_q  in  DATA_WIDTH  instruction from the ROM, combinational on rom_addr.
- rom_addr  out  ADDR_WIDTH  ROM word address.
- pc_if  out  DATA_WIDTH  current fetch PC.
- instr_id  out  DATA_WIDTH  IF/ID instruction.
- pc_plus4_id  out  DATA_WIDTH  IF/ID PC+4 of that instruction.
- valid_id  out  1  IF/ID holds a real instruction; 0 means bubble.
- addr_err  out  1  sticky fetch-address error.
- fetch_count  out  CNT_WIDTH  number of instructions accepted into IF/ID.

Behaviour:
- Reset, sampled on the clk edge:
  - pc_if = RESET_PC.
  - instr_id = 0, which is sll $0,$0,0 (nop).
  - pc_plus4_id = 0, valid_id = 0, addr_err = 0, fetch_count = 0.
  - Reset mid-operation discards every pending request in the same cycle.
- Address mapping:
  - off = pc_if - RESET_PC, modulo 2**DATA_WIDTH.
  - rom_addr = off[ADDR_WIDTH+1:2], purely combinational from pc_if.
  - in_range = (off >> 2) < 2**ADDR_WIDTH.
- Fetch latency: the instruction at pc_if appears on instr_id one clock later. There is one cycle from PC to IF/ID.
- Per-edge priority, with reset not asserted:
  1. redirect_en=1, whatever the values of stall and flush:
     - pc_if <= {redirect_pc[DATA_WIDTH-1:2], 2'b00}.
     - IF/ID <= bubble, i.e. instr_id=0, pc_plus4_id=0, valid_id=0.
     - If redirect_pc[1:0] != 0, addr_err <= 1.
  2. Else if stall=1:
     - pc_if holds.
     - If flush=1, IF/ID <= bubble; otherwise IF/ID holds.
     - fetch_count holds.
  3. Else if flush=1: pc_if <= pc_if+4 and IF/ID <= bubble.
  4. Else, a normal fetch:
     - pc_if <= pc_if+4.
     - If in_range: instr_id <= rom_q, pc_plus4_id <= pc_if+4, valid_id <= 1.
     - If not in_range: IF/ID <= bubble and addr_err <= 1.
- fetch_count increments only on a normal fetch with in_range=1 that loads valid_id=1. It saturates at all ones and does not wrap.
- PC increment wraps modulo 2**DATA_WIDTH. An out-of-range result is reported through addr_err and is not prevented.
- addr_err stays set until reset. It does not stop fetching.
- Outputs are registered, except rom_addr, which is combinational from pc_if.

Test Plan:
- Reset then 4 free-running cycles, with ROM words 0..3 = 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000:
  - instr_id shows those words on cycles 1..4.
  - pc_plus4_id = 0x00400004, 0x00400008, 0x0040000C, 0x00400010.
  - fetch_count = 4 and valid_id = 1 throughout.
- stall held 3 cycles at pc_if = 0x00400008: pc_if, instr_id and fetch_count are frozen; release resumes with word 2 on the next edge.
- redirect_en with redirect_pc = 0x00400020 and stall=1 in the same cycle:
  - Next cycle pc_if = 0x00400020, rom_addr = 8 and valid_id = 0.
  - One cycle later instr_id = ROM word 8 and valid_id = 1.
- flush alone at pc_if = 0x00400004: valid_id = 0 and instr_id = 0, pc_if = 0x00400008, fetch_count unchanged.
- redirect_pc = 0x00400006: pc_if = 0x00400004 and addr_err = 1. addr_err remains 1 through 10 normal cycles and clears only on reset.
- redirect to 0x00400400 with ADDR_WIDTH=8: the next fetch gives valid_id = 0 and addr_err = 1, and pc_if advances to 0x00400404.
